// File: rtl/serial_chunk_adder.sv
// Serial adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, with a valid/ready handshake on both sides.
module serial_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Reject configurations where the operand does not split into whole chunks
    if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_cfg
        $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;

    logic [CHUNK:0]       sum_c;
    logic                 ovf_c;
    logic [WIDTH+CHUNK-1:0] res_ext_c;
    logic [WIDTH-1:0]     res_nxt_c;

    // Current chunk add; operands shift right so the live chunk is always at the bottom
    always_comb begin
        sum_c     = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry};
        // carry into the MSB is a^b^s at that bit; XOR with carry out gives overflow
        ovf_c     = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ sum_c[CHUNK-1] ^ sum_c[CHUNK];
        res_ext_c = {sum_c[CHUNK-1:0], res};
        res_nxt_c = res_ext_c[WIDTH+CHUNK-1:CHUNK];
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    res   <= res_nxt_c;
                    carry <= sum_c[CHUNK];
                    if (cnt == LAST) begin
                        s         <= res_nxt_c;
                        cout      <= sum_c[CHUNK];
                        ovf       <= ovf_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per clock cycle; WIDTH mod CHUNK SHALL be 0, and N = WIDTH/CHUNK.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit: the operand set is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts operands.
REQ-007 Port a, input, WIDTH bits: operand A; bit 0 is the LSB.
REQ-008 Port b, input, WIDTH bits: operand B; bit 0 is the LSB.
REQ-009 Port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-010 Port sub, input, 1 bit: 0 selects a+b+cin, 1 selects a-b.
REQ-011 Port out_valid, output, 1 bit: the result is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port s, output, WIDTH bits: sum or difference, modulo 2^WIDTH.
REQ-014 Port cout, output, 1 bit: carry out of bit WIDTH-1; for sub=1, 1 means no borrow.
REQ-015 Port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-018 On an in_valid&&in_ready edge, the block SHALL capture a, the effective operand (sub ? ~b : b) and the initial carry (sub ? 1 : cin), clear the chunk counter, and enter RUN.
REQ-019 In RUN, each cycle SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1, LSB chunk first) together with the registered carry, store that result chunk and the chunk carry-out, then increment k.
REQ-020 After chunk N-1 is processed, the FSM SHALL enter DONE; out_valid SHALL rise exactly N clock edges after the accepting edge.
REQ-021 The block SHALL register cout as the carry out of bit WIDTH-1 and ovf as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-022 In DONE, s, cout and ovf SHALL remain stable while out_ready=0.
REQ-023 On an out_valid&&out_ready edge, the FSM SHALL return to IDLE; in_ready SHALL rise on the following cycle, so there is no same-cycle re-accept.
REQ-024 The block SHALL ignore in_valid outside IDLE; changes on a, b, cin and sub after capture SHALL NOT affect the result.
REQ-025 With CHUNK=WIDTH, RUN SHALL last exactly one cycle, giving latency 1.
REQ-026 The block SHALL keep s, cout and ovf at their last result in IDLE until the next DONE overwrites them.
REQ-027 The chunk counter SHALL be ceil(log2(N)) bits wide, minimum 1 bit, and SHALL never wrap past N-1.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force state IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, counter=0 and internal operand and carry registers to 0.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation, and no out_valid SHALL follow it.
REQ-030 On the first rising edge after rst_n deasserts, the block SHALL be able to accept operands.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-031 The bench SHALL apply a=0xFFFF, b=0x0001, cin=0, sub=0 -> out_valid 4 edges after accept, s=0x0000, cout=1, ovf=0.
REQ-032 The bench SHALL apply a=0x7FFF, b=0x0001, cin=0, sub=0 -> s=0x8000, cout=0, ovf=1; then a=0x1234, b=0x4321, cin=1 -> s=0x5556, cout=0, ovf=0.
REQ-033 The bench SHALL apply a=0x0005, b=0x0007, sub=1, cin=1 -> s=0xFFFE, cout=0, ovf=0 (cin ignored); then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
REQ-034 The bench SHALL hold out_ready=0 for 3 cycles in DONE while toggling a, b and in_valid -> s, cout and ovf stay stable, in_ready=0, and no second capture occurs.
REQ-035 The bench SHALL assert rst_n=0 during RUN cycle 2 -> all outputs immediately go to their reset values, no out_valid follows, and the next operand set is computed correctly.
REQ-036 The bench SHALL run with CHUNK=16 and apply a=0xFFFF, b=0xFFFF, cin=1 -> out_valid 1 edge after accept, s=0xFFFF, cout=1, ovf=0.
